axis_pkt_gen: RTL and testbench

// AXI-Stream packet transmitter. Accepts one command per packet: byte length, seed byte, TID, TUSER.

---
 rtl/axis_pkg.sv | 26 ++
 rtl/axis_pkt_gen.sv | 160 ++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and beat-building helpers for the AXI-Stream packet generator.
package axis_pkg;

    typedef enum logic [0:0] {GEN_IDLE, GEN_SEND} gen_state_t;

    // Helpers are sized for the widest supported bus; callers truncate to their own width.
    localparam int unsigned MAX_LANES = 64;

    function automatic logic [MAX_LANES-1:0] keep_for_bytes(input int unsigned remaining);
        logic [MAX_LANES-1:0] keep;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            keep[i] = (i < remaining);
        end
        return keep;
    endfunction

    function automatic logic [MAX_LANES*8-1:0] pattern_beat(input logic [7:0] seed,
                                                            input logic [7:0] base);
        logic [MAX_LANES*8-1:0] data;
        for (int i = 0; i < MAX_LANES; i++) begin
            data[i*8 +: 8] = seed + base + 8'(i);
        end
        return data;
    endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - AXI-Stream packet source with incrementing byte pattern.
// One command per packet; partial tkeep and tlast on the final beat.
module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int WIDTH_TDATA = 32,
    parameter int WIDTH_TUSER = 1,
    parameter int WIDTH_TID   = 4,
    parameter int WIDTH_TKEEP = 4,
    parameter int WIDTH_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH_LEN-1:0]   cmd_len,
    input  logic [7:0]             cmd_seed,
    input  logic [WIDTH_TID-1:0]   cmd_tid,
    input  logic [WIDTH_TUSER-1:0] cmd_tuser,
    output logic                   axis_s_tvalid,
    output logic [WIDTH_TDATA-1:0] axis_s_tdata,
    output logic [WIDTH_TUSER-1:0] axis_s_tuser,
    output logic [WIDTH_TID-1:0]   axis_s_tid,
    output logic [WIDTH_TKEEP-1:0] axis_s_tkeep,
    output logic                   axis_s_tlast,
    input  logic                   axis_s_tready,
    output logic                   busy,
    output logic                   pkt_done,
    output logic [15:0]            pkt_cnt
);

    localparam int unsigned          BYTES   = WIDTH_TDATA / 8;
    localparam logic [WIDTH_LEN-1:0] BYTES_L = WIDTH_LEN'(BYTES);
    localparam logic [7:0]           BYTES_B = 8'(BYTES);

    generate
        if (WIDTH_TDATA % 8 != 0) begin : g_bad_tdata
            $error("axis_pkt_gen: WIDTH_TDATA must be a multiple of 8");
        end
        if (WIDTH_TKEEP != WIDTH_TDATA / 8) begin : g_bad_tkeep
            $error("axis_pkt_gen: WIDTH_TKEEP must equal WIDTH_TDATA/8");
        end
    endgenerate

    gen_state_t           state;
    logic [WIDTH_LEN-1:0] remaining;
    logic [7:0]           base;
    logic [7:0]           seed_q;

    logic                   accept;
    logic                   beat_hs;
    logic                   last_hs;
    logic                   cmd_empty;
    logic [WIDTH_LEN-1:0]   load_rem;
    logic [7:0]             load_base;
    logic [7:0]             load_seed;
    int unsigned            load_avail;
    logic [WIDTH_TDATA-1:0] load_pat;
    logic [WIDTH_TDATA-1:0] load_data;
    logic [WIDTH_TKEEP-1:0] load_keep;
    logic                   load_last;

    assign cmd_ready = (state == GEN_IDLE) && !rst;
    assign busy      = (state == GEN_SEND);

    // Next beat to present: either beat 0 of a fresh command or the successor of the current beat.
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        beat_hs   = axis_s_tvalid && axis_s_tready;
        last_hs   = beat_hs && axis_s_tlast;
        cmd_empty = (cmd_len == '0);
        if (accept) begin
            load_rem  = cmd_len;
            load_base = 8'd0;
            load_seed = cmd_seed;
        end else begin
            load_rem  = remaining - BYTES_L;
            load_base = base + BYTES_B;
            load_seed = seed_q;
        end
        if (load_rem >= BYTES_L) begin
            load_avail = BYTES;
        end else begin
            load_avail = 32'(load_rem);
        end
        load_keep = WIDTH_TKEEP'(keep_for_bytes(load_avail));
        load_pat  = WIDTH_TDATA'(pattern_beat(load_seed, load_base));
        for (int i = 0; i < WIDTH_TKEEP; i++) begin
            load_data[i*8 +: 8] = load_pat[i*8 +: 8] & {8{load_keep[i]}};
        end
        load_last = (load_rem <= BYTES_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GEN_IDLE;
            remaining <= '0;
            base      <= 8'd0;
            seed_q    <= 8'd0;
        end else begin
            case (state)
                GEN_IDLE: begin
                    if (accept && !cmd_empty) begin
                        state     <= GEN_SEND;
                        remaining <= load_rem;
                        base      <= load_base;
                        seed_q    <= load_seed;
                    end
                end
                GEN_SEND: begin
                    if (last_hs) begin
                        state <= GEN_IDLE;
                    end else if (beat_hs) begin
                        remaining <= load_rem;
                        base      <= load_base;
                    end
                end
                default: state <= GEN_IDLE;
            endcase
        end
    end

    // Stream outputs only move on accept or handshake, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            axis_s_tvalid <= 1'b0;
            axis_s_tdata  <= '0;
            axis_s_tuser  <= '0;
            axis_s_tid    <= '0;
            axis_s_tkeep  <= '0;
            axis_s_tlast  <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_cnt       <= 16'd0;
        end else begin
            pkt_done <= 1'b0;
            if (accept) begin
                if (cmd_empty) begin
                    pkt_done <= 1'b1;
                    pkt_cnt  <= pkt_cnt + 16'd1;
                end else begin
                    axis_s_tvalid <= 1'b1;
                    axis_s_tdata  <= load_data;
                    axis_s_tkeep  <= load_keep;
                    axis_s_tlast  <= load_last;
                    axis_s_tid    <= cmd_tid;
                    axis_s_tuser  <= cmd_tuser;
                end
            end else if (last_hs) begin
                axis_s_tvalid <= 1'b0;
                pkt_done      <= 1'b1;
                pkt_cnt       <= pkt_cnt + 16'd1;
            end else if (beat_hs) begin
                axis_s_tdata <= load_data;
                axis_s_tkeep <= load_keep;
                axis_s_tlast <= load_last;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb/tb_axis_pkt_gen.sv - self-checking bench for axis_pkt_gen against a byte-level packet model.
module tb_axis_pkt_gen;

    localparam int BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic [3:0]  cmd_tid;
    logic [0:0]  cmd_tuser;
    logic        axis_s_tvalid;
    logic [31:0] axis_s_tdata;
    logic [0:0]  axis_s_tuser;
    logic [3:0]  axis_s_tid;
    logic [3:0]  axis_s_tkeep;
    logic        axis_s_tlast;
    logic        axis_s_tready;
    logic        busy;
    logic        pkt_done;
    logic [15:0] pkt_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;
    logic [31:0] got_data[$];

    always #5 clk = ~clk;

    axis_pkt_gen dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .cmd_tid       (cmd_tid),
        .cmd_tuser     (cmd_tuser),
        .axis_s_tvalid (axis_s_tvalid),
        .axis_s_tdata  (axis_s_tdata),
        .axis_s_tuser  (axis_s_tuser),
        .axis_s_tid    (axis_s_tid),
        .axis_s_tkeep  (axis_s_tkeep),
        .axis_s_tlast  (axis_s_tlast),
        .axis_s_tready (axis_s_tready),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .pkt_cnt       (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one command at a negedge and follows the packet to completion.
    // Returns at the negedge right after the tlast handshake (or the len==0 completion).
    task automatic run_pkt(input int len, input logic [7:0] seed, input logic [3:0] tid,
                           input logic tuser, input int stall_beat, input int stall_cycles,
                           input bit rand_ready, input bit keep_valid);
        int          nbeats;
        int          waits;
        int          k;
        bit          rdy;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic [31:0] seen;
        got_data.delete();
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_tid   = tid;
        cmd_tuser = tuser;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        if (keep_valid) begin
            cmd_len   = 16'($urandom_range(1, 60));
            cmd_seed  = 8'($urandom);
            cmd_tid   = 4'($urandom);
            cmd_tuser = 1'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        if (len == 0) begin
            exp_cnt++;
            chk("len0_tvalid", axis_s_tvalid, 0);
            chk("len0_pkt_done", pkt_done, 1);
            chk("len0_pkt_cnt", pkt_cnt, exp_cnt);
            chk("len0_cmd_ready", cmd_ready, 1);
            return;
        end
        chk("start_pkt_done", pkt_done, 0);
        chk("start_cmd_ready", cmd_ready, 0);
        nbeats = (len + BYTES - 1) / BYTES;
        for (int b = 0; b < nbeats; b++) begin
            waits = 0;
            for (int i = 0; i < BYTES; i++) begin
                k = b * BYTES + i;
                if (k < len) begin
                    ed[i*8 +: 8] = seed + 8'(k);
                    ek[i]        = 1'b1;
                end else begin
                    ed[i*8 +: 8] = 8'h00;
                    ek[i]        = 1'b0;
                end
            end
            forever begin
                chk("beat_tvalid", axis_s_tvalid, 1);
                chk("beat_tdata", axis_s_tdata, ed);
                chk("beat_tkeep", axis_s_tkeep, ek);
                chk("beat_tlast", axis_s_tlast, (b == nbeats - 1));
                chk("beat_tid", axis_s_tid, tid);
                chk("beat_tuser", axis_s_tuser, tuser);
                chk("beat_busy", busy, 1);
                if (b == stall_beat && waits < stall_cycles) rdy = 1'b0;
                else if (rand_ready && waits < 6) rdy = ($urandom_range(0, 2) != 0);
                else rdy = 1'b1;
                seen = axis_s_tdata;
                axis_s_tready = rdy;
                @(negedge clk);
                if (rdy) begin
                    got_data.push_back(seen);
                    break;
                end
                waits++;
            end
        end
        axis_s_tready = 1'($urandom_range(0, 1));
        exp_cnt++;
        chk("end_tvalid", axis_s_tvalid, 0);
        chk("end_pkt_done", pkt_done, 1);
        chk("end_busy", busy, 0);
        chk("end_pkt_cnt", pkt_cnt, exp_cnt);
        chk("end_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_len       = 16'd0;
        cmd_seed      = 8'd0;
        cmd_tid       = 4'd0;
        cmd_tuser     = 1'b0;
        axis_s_tready = 1'b0;
        exp_cnt       = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", axis_s_tvalid, 0);
        chk("rst_tlast", axis_s_tlast, 0);
        chk("rst_tdata", axis_s_tdata, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run_pkt(10, 8'h00, 4'h1, 1'b0, -1, 0, 1'b0, 1'b0);
        chk("t1_beats", got_data.size(), 3);
        chk("t1_beat2", got_data[2], 32'h0000_0908);

        run_pkt(4, 8'hFE, 4'h2, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("t2_beats", got_data.size(), 1);
        chk("t2_beat0", got_data[0], 32'h0100_FFFE);

        run_pkt(12, 8'($urandom), 4'h3, 1'b0, 1, 5, 1'b0, 1'b0);
        chk("t3_beats", got_data.size(), 3);

        run_pkt(0, 8'h55, 4'h4, 1'b0, -1, 0, 1'b0, 1'b0);

        run_pkt(5, 8'h10, 4'h6, 1'b1, -1, 0, 1'b0, 1'b1);
        run_pkt(3, 8'h20, 4'h7, 1'b0, -1, 0, 1'b0, 1'b0);
        chk("t5_beat0", got_data[0], 32'h0022_2120);

        for (int n = 0; n < 20; n++) begin
            run_pkt($urandom_range(0, 40), 8'($urandom), 4'($urandom), 1'($urandom),
                    -1, 0, 1'b1, 1'b0);
        end

        cmd_valid = 1'b1;
        cmd_len   = 16'd16;
        cmd_seed  = 8'h40;
        cmd_tid   = 4'h5;
        cmd_tuser = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t6_beat0", axis_s_tdata, 32'h4342_4140);
        axis_s_tready = 1'b1;
        @(negedge clk);
        axis_s_tready = 1'b0;
        chk("t6_beat1_valid", axis_s_tvalid, 1);
        chk("t6_beat1", axis_s_tdata, 32'h4746_4544);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tvalid", axis_s_tvalid, 0);
        chk("t6_rst_pkt_done", pkt_done, 0);
        chk("t6_rst_pkt_cnt", pkt_cnt, 0);
        chk("t6_rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("t6_post_pkt_done", pkt_done, 0);
        chk("t6_post_tvalid", axis_s_tvalid, 0);
        run_pkt(6, 8'h90, 4'h9, 1'b0, -1, 0, 1'b0, 1'b0);
        chk("t6_new_beat0", got_data[0], 32'h9392_9190);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
